branch_resolver: RTL and testbench

//  Drives the predictor's query/update interface from a stream of resolved branch outcomes.
//  Per branch:
//   - accepts one outcome on a valid/ready handshake;
//   - queries the predictor (predict_req/predict);
//   - waits a modelled resolve latency;
//   - issues the update (result/result_strob);
//   - scores the prediction into saturating hit/total counters.

---
 rtl/branch_resolver.sv | 121 ++++++++++++
 tb/tb_branch_resolver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_resolver: queries a predictor per branch outcome and issues its     |
// | update after a modelled resolve latency, scoring hits into stat counters.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module branch_resolver #(
  parameter int RESOLVE_LAT = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             br_valid,
  input  logic             br_taken,
  output logic             br_ready,
  output logic             predict_req,
  input  logic             predict,
  output logic             result,
  output logic             result_strob,
  output logic             mispredict,
  output logic             last_pred,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_hit
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESOLVE = 2'd3;

  localparam logic [3:0]       c_wait_load = (RESOLVE_LAT > 0) ? 4'(RESOLVE_LAT - 1) : 4'd0;
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [3:0]       r_wait_cnt;
  logic             r_taken;
  logic             r_pred;
  logic [CNT_W-1:0] r_cnt_total;
  logic [CNT_W-1:0] r_cnt_hit;
  logic             w_accept;
  logic             w_hit;

  assign w_accept = br_valid && (r_state == S_IDLE);
  assign w_hit    = (r_pred == r_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = S_REQ;
      S_REQ:     w_next_state = (RESOLVE_LAT > 0) ? S_WAIT : S_RESOLVE;
      S_WAIT:    if (r_wait_cnt == 4'd0) w_next_state = S_RESOLVE;
      S_RESOLVE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    br_ready     = 1'b0;
    predict_req  = 1'b0;
    result_strob = 1'b0;
    result       = 1'b0;
    mispredict   = 1'b0;
    case (r_state)
      S_IDLE:    br_ready = 1'b1;
      S_REQ:     predict_req = 1'b1;
      S_RESOLVE: begin
        result_strob = 1'b1;
        result       = r_taken;
        mispredict   = !w_hit;
      end
      default:   ;
    endcase
  end

  // Only a driven 1 counts as taken; a floating or unknown answer scores as not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken    <= 1'b0;
      r_pred     <= 1'b0;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_accept) r_taken <= br_taken;
      if (r_state == S_REQ) begin
        r_pred     <= (predict === 1'b1);
        r_wait_cnt <= c_wait_load;
      end else if (r_state == S_WAIT && r_wait_cnt != 4'd0) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end
    end
  end

  // Clear takes priority, so a branch resolving in the clear cycle is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_total <= '0;
      r_cnt_hit   <= '0;
    end else if (clr) begin
      r_cnt_total <= '0;
      r_cnt_hit   <= '0;
    end else if (r_state == S_RESOLVE) begin
      if (r_cnt_total != c_cnt_max) r_cnt_total <= r_cnt_total + 1'b1;
      if (w_hit && r_cnt_hit != c_cnt_max) r_cnt_hit <= r_cnt_hit + 1'b1;
    end
  end

  assign last_pred = r_pred;
  assign cnt_total = r_cnt_total;
  assign cnt_hit   = r_cnt_hit;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolver.sv
`default_nettype none
// Directed bench for branch_resolver: main instance (LAT=2), a 4-bit counter
// instance sharing its stimulus, and a zero-latency instance.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        br_ready, predict_req, predict, result, result_strob, mispredict, last_pred;
  logic [15:0] cnt_total, cnt_hit;

  logic        s_ready, s_req, s_predict, s_result, s_strob, s_mp, s_last;
  logic [3:0]  s_total, s_hit;

  logic        z_valid = 1'b0;
  logic        z_taken = 1'b0;
  logic        z_ready, z_req, z_predict, z_result, z_strob, z_mp, z_last;
  logic [15:0] z_total, z_hit;

  int          mode = 0;
  logic        cur_taken = 1'b0;
  logic        bp_rst = 1'b0;
  logic [1:0]  bp_ctr;
  logic        pv;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_acc = 0;
  int acc_gap  = 0;
  int miss_cnt = 0;
  int strob_cnt = 0;

  always #5 clk = ~clk;

  branch_resolver #(.RESOLVE_LAT(2), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_taken(br_taken), .br_ready(br_ready),
    .predict_req(predict_req), .predict(predict), .result(result), .result_strob(result_strob),
    .mispredict(mispredict), .last_pred(last_pred), .clr(clr),
    .cnt_total(cnt_total), .cnt_hit(cnt_hit)
  );

  branch_resolver #(.RESOLVE_LAT(2), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_taken(br_taken), .br_ready(s_ready),
    .predict_req(s_req), .predict(s_predict), .result(s_result), .result_strob(s_strob),
    .mispredict(s_mp), .last_pred(s_last), .clr(clr),
    .cnt_total(s_total), .cnt_hit(s_hit)
  );

  branch_resolver #(.RESOLVE_LAT(0), .CNT_W(16)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .br_valid(z_valid), .br_taken(z_taken), .br_ready(z_ready),
    .predict_req(z_req), .predict(z_predict), .result(z_result), .result_strob(z_strob),
    .mispredict(z_mp), .last_pred(z_last), .clr(clr),
    .cnt_total(z_total), .cnt_hit(z_hit)
  );

  // Predictor answers: 0 = always not-taken, 1 = oracle, 2 = 2-bit counter.
  always_comb begin
    pv = 1'b0;
    case (mode)
      1:       pv = cur_taken;
      2:       pv = bp_ctr[1];
      default: pv = 1'b0;
    endcase
  end

  assign predict   = predict_req ? pv : 1'bz;
  assign s_predict = s_req ? pv : 1'bz;
  assign z_predict = z_req ? 1'b1 : 1'bz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || bp_rst) bp_ctr <= 2'd0;
    else if (result_strob) begin
      if (result && bp_ctr != 2'd3) bp_ctr <= bp_ctr + 2'd1;
      else if (!result && bp_ctr != 2'd0) bp_ctr <= bp_ctr - 2'd1;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (br_valid && br_ready) begin
      acc_gap  <= cyc - last_acc;
      last_acc <= cyc;
    end
  end

  always @(negedge clk) begin
    if (mispredict) miss_cnt <= miss_cnt + 1;
    if (result_strob) strob_cnt <= strob_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic send_branch(input logic t, input bit wait_res, output logic mp);
    int n;
    n = 0;
    mp = 1'b0;
    @(negedge clk);
    while (!br_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!br_ready) check("ready_timeout", 0, 1);
    br_valid  = 1'b1;
    br_taken  = t;
    cur_taken = t;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    br_taken = 1'b0;
    if (wait_res) begin
      n = 0;
      @(negedge clk);
      while (!result_strob && n < 30) begin
        @(negedge clk);
        n++;
      end
      if (!result_strob) check("strob_timeout", 0, 1);
      mp = mispredict;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    logic mp;
    logic [7:0] pat;
    int s0;
    pat = 8'b0100_1101;  // T,N,T,T,N,N,T,N from bit 0 upward

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", br_ready, 1);
    check("rst_outs", {predict_req, result_strob, result, mispredict, last_pred}, 0);
    check("rst_cnts", {cnt_total, cnt_hit}, 0);
    check("rst_lat0_ready", z_ready, 1);

    // Single miss, predictor answers 0
    mode = 0;
    send_branch(1'b1, 0, mp);
    @(negedge clk);
    check("e0_req", {predict_req, result_strob}, 2'b10);
    @(negedge clk);
    check("e1_req", {predict_req, result_strob}, 2'b00);
    @(negedge clk);
    check("e2_strob", result_strob, 0);
    @(negedge clk);
    check("e3_resolve", {predict_req, result_strob, result, mispredict}, 4'b0111);
    @(negedge clk);
    check("e4_idle", {result_strob, result, mispredict, br_ready}, 4'b0001);
    check("miss_total", cnt_total, 1);
    check("miss_hit", cnt_hit, 0);
    check("miss_last_pred", last_pred, 0);

    // Clear outside RESOLVE
    pulse_clr();
    check("clr_cnts", {cnt_total, cnt_hit}, 0);

    // Back-to-back stream with oracle predictor
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      send_branch(pat[i], 1, mp);
      check("oracle_mp", mp, 0);
      if (i > 0) check("accept_gap", acc_gap, 5);
    end
    @(negedge clk);
    check("oracle_total", cnt_total, 8);
    check("oracle_hit", cnt_hit, 8);

    // Closed loop: 2-bit counter from 0 mispredicts the first two taken branches
    pulse_clr();
    mode = 2;
    bp_rst = 1'b1;
    @(negedge clk);
    bp_rst = 1'b0;
    s0 = miss_cnt;
    for (int i = 0; i < 40; i++) begin
      send_branch(1'b1, 1, mp);
      check("loop_mp", mp, (i < 2) ? 1 : 0);
    end
    @(negedge clk);
    check("loop_miss_cnt", miss_cnt - s0, 2);
    check("loop_total", cnt_total, 40);
    check("loop_hit", cnt_hit, 38);
    check("sat_total", s_total, 15);
    check("sat_hit", s_hit, 15);

    // Clear coinciding with RESOLVE wins over the increment
    send_branch(1'b1, 1, mp);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_res_main", {cnt_total, cnt_hit}, 0);
    check("clr_res_sat", {s_total, s_hit}, 0);

    // Reset during WAIT drops the branch
    send_branch(1'b1, 0, mp);
    @(negedge clk);
    @(negedge clk);
    s0 = strob_cnt;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_strob", strob_cnt - s0, 0);
    check("midrst_ready", br_ready, 1);
    check("midrst_last", last_pred, 0);

    // Zero latency: predictor says taken, branch not taken
    @(negedge clk);
    z_valid = 1'b1;
    z_taken = 1'b0;
    @(posedge clk);
    #1;
    z_valid = 1'b0;
    @(negedge clk);
    check("lat0_e0", {z_req, z_strob}, 2'b10);
    @(negedge clk);
    check("lat0_e1", {z_req, z_strob, z_result, z_mp}, 4'b0101);
    @(negedge clk);
    check("lat0_e2", {z_strob, z_ready, z_last}, 3'b011);
    check("lat0_cnts", {z_total, z_hit}, {16'd1, 16'd0});

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
